k_frame_writer: RTL
===================

K_FRAME_WRITER -- requirements
Module: k_frame_writer

Interface
REQ-001 The module SHALL have these parameters:
- DATA_W, default 8: pixel width in bits.
- COL_W, default 8: column address width.
- ROW_W, default 3: row address width.
- COLS, default 240: pixels per row; COLS <= 2**COL_W.
- ROWS, default 8: rows per frame; ROWS <= 2**ROW_W.

REQ-002 The module SHALL have these ports (clock and reset first):
- clk  in  1: sole clock; all logic on its rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- start  in  1: arms one frame write; sampled in IDLE only.
- enable  in  1: acceptance gate; low stalls the frame.
- pix_valid  in  1: upstream pixel valid.
- pix_data  in  DATA_W: upstream pixel.
- pix_ready  out  1: pixel accepted this cycle when high together with pix_valid.
- mem_we  out  1: frame-memory write strobe.
- mem_col  out  COL_W: write column address.
- mem_row  out  ROW_W: write row address.
- mem_wdata  out  DATA_W: write data.
- busy  out  1: high whenever state is not IDLE.
- frame_done  out  1: one-cycle pulse when a frame completes.
- row_done  out  1: one-cycle pulse per completed row (see Configuration).

Function
REQ-003 The FSM SHALL have states IDLE, WRITE and DONE.
REQ-004 In IDLE, start=1 SHALL move the FSM to WRITE and clear the column and row counters to 0.
REQ-005 In WRITE, pix_ready SHALL equal enable combinationally; a transfer is pix_valid && pix_ready.
REQ-006 Each transfer SHALL produce, on the next cycle only:
- mem_we=1;
- mem_col and mem_row equal to the counter values at transfer time;
- mem_wdata equal to pix_data at transfer time.
This is a fixed write latency of 1 cycle.
REQ-007 mem_we SHALL be 0 in every cycle not following a transfer.
REQ-008 On a transfer with col < COLS-1, col SHALL increment by 1.
REQ-009 On a transfer with col == COLS-1, col SHALL wrap to 0 and row SHALL increment by 1.
REQ-010 A transfer with col == COLS-1 and row == ROWS-1 SHALL move the FSM to DONE, and the counters SHALL return to 0.
REQ-011 DONE SHALL last exactly one cycle, with frame_done=1, and then return to IDLE. This cycle coincides with the mem_we of the last pixel.
REQ-012 pix_ready SHALL be 0 in IDLE and DONE.
REQ-013 start SHALL be ignored in WRITE and DONE; a new frame requires start while in IDLE.
REQ-014 When enable is low in WRITE, the counters and state SHALL hold and no transfer SHALL occur.
REQ-015 busy SHALL be 1 in WRITE and DONE and 0 in IDLE.

Reset
REQ-016 On rst_n=0, regardless of clock, the module SHALL immediately:
- enter IDLE;
- clear both counters;
- drive mem_we, mem_col, mem_row, mem_wdata, busy, frame_done and row_done to 0.
REQ-017 Reset asserted mid-frame SHALL abandon the frame: no further mem_we and no frame_done until a new start after reset release.

Configuration
REQ-018 When macro K_FRAME_WRITER_ROW_DONE_EN is defined, row_done SHALL pulse for one cycle together with the mem_we of each row's last pixel (col == COLS-1), including the final row.
REQ-019 When K_FRAME_WRITER_ROW_DONE_EN is undefined, the row_done port SHALL remain and be tied to constant 0, and no row-pulse logic SHALL be built.

Verification
Bench parameters: COLS=4, ROWS=2, DATA_W=8.

REQ-020 Reset then idle:
- Stimulus: rst_n low, then release; start=0; pix_valid=1 for 10 cycles.
- Response: pix_ready=0, mem_we=0, busy=0 throughout.

REQ-021 Full frame:
- Stimulus: start pulse; enable=1; 8 back-to-back pixels 0x10..0x17.
- Response: 8 mem_we cycles, each one cycle after its transfer, with addresses (r0,c0)..(r0,c3), (r1,c0)..(r1,c3) and data 0x10..0x17.
- Response: frame_done=1 only on the cycle writing 0x17; busy=0 on the following cycle.

REQ-022 Stall:
- Stimulus: enable dropped for 3 cycles after the 2nd pixel.
- Response: pix_ready=0 and no mem_we during the stall; the 3rd pixel is written to (r0,c2); the frame completes normally.

REQ-023 Reset mid-frame:
- Stimulus: rst_n pulsed low after 5 transfers; then start again with 8 pixels.
- Response: all outputs 0 immediately on reset; the new frame starts at (r0,c0) and frame_done fires exactly once.

REQ-024 Start ignored while busy:
- Stimulus: start held 1 throughout a frame.
- Response: exactly one frame_done; the FSM returns to IDLE, then re-enters WRITE on the next cycle, since start is still 1.

REQ-025 Macro on/off:
- With K_FRAME_WRITER_ROW_DONE_EN defined, row_done pulses with the writes to (r0,c3) and (r1,c3).
- Without it, row_done stays 0.

Source files
------------

// File: rtl/k_frame_writer_if.sv
// Pixel handshake and frame-memory write bus for k_frame_writer.
// The slave modport is the writer itself; the master modport is the pixel source / memory side.
interface k_frame_writer_if #(
   parameter int DATA_W = 8,
   parameter int COL_W  = 8,
   parameter int ROW_W  = 3
);
   logic              pix_valid;
   logic [DATA_W-1:0] pix_data;
   logic              pix_ready;
   logic              mem_we;
   logic [COL_W-1:0]  mem_col;
   logic [ROW_W-1:0]  mem_row;
   logic [DATA_W-1:0] mem_wdata;

   modport slave (
      input  pix_valid,
      input  pix_data,
      output pix_ready,
      output mem_we,
      output mem_col,
      output mem_row,
      output mem_wdata
   );

   modport master (
      output pix_valid,
      output pix_data,
      input  pix_ready,
      input  mem_we,
      input  mem_col,
      input  mem_row,
      input  mem_wdata
   );
endinterface

// File: rtl/k_frame_writer.sv
// Raster frame writer: accepts a pixel stream and writes it row by row into frame memory.
// Optional per-row pulse on row_done is built only when K_FRAME_WRITER_ROW_DONE_EN is defined.
module k_frame_writer #(
   parameter int DATA_W = 8,
   parameter int COL_W  = 8,
   parameter int ROW_W  = 3,
   parameter int COLS   = 240,
   parameter int ROWS   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  enable,
   k_frame_writer_if.slave       bus,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  row_done
);

   typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   state_t            state_q;
   logic [COL_W-1:0]  colCnt_q;
   logic [COL_W-1:0]  colCnt_d;
   logic [ROW_W-1:0]  rowCnt_q;
   logic [ROW_W-1:0]  rowCnt_d;
   logic              memWe_q;
   logic [COL_W-1:0]  memCol_q;
   logic [ROW_W-1:0]  memRow_q;
   logic [DATA_W-1:0] memWdata_q;
   logic              frameDone_q;
   logic              xfer;
   logic              lastCol;
   logic              lastRow;

   assign bus.pix_ready = (state_q == WRITE) && enable;
   assign xfer          = bus.pix_valid && bus.pix_ready;
   assign lastCol       = (colCnt_q == LAST_COL);
   assign lastRow       = (rowCnt_q == LAST_ROW);

   // Raster advance: column wraps into the next row; the last pixel returns both counters to 0.
   always_comb begin
      colCnt_d = colCnt_q;
      rowCnt_d = rowCnt_q;
      if (xfer) begin
         if (lastCol) begin
            colCnt_d = '0;
            rowCnt_d = lastRow ? '0 : rowCnt_q + 1'b1;
         end else begin
            colCnt_d = colCnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         colCnt_q    <= '0;
         rowCnt_q    <= '0;
         memWe_q     <= 1'b0;
         memCol_q    <= '0;
         memRow_q    <= '0;
         memWdata_q  <= '0;
         frameDone_q <= 1'b0;
      end else begin
         memWe_q     <= xfer;
         frameDone_q <= 1'b0;
         if (xfer) begin
            memCol_q   <= colCnt_q;
            memRow_q   <= rowCnt_q;
            memWdata_q <= bus.pix_data;
         end
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q  <= WRITE;
                  colCnt_q <= '0;
                  rowCnt_q <= '0;
               end
            end
            WRITE: begin
               colCnt_q <= colCnt_d;
               rowCnt_q <= rowCnt_d;
               // DONE lines up with the memory write of the final pixel.
               if (xfer && lastCol && lastRow) begin
                  state_q     <= DONE;
                  frameDone_q <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy          = (state_q != IDLE);
   assign frame_done    = frameDone_q;
   assign bus.mem_we    = memWe_q;
   assign bus.mem_col   = memCol_q;
   assign bus.mem_row   = memRow_q;
   assign bus.mem_wdata = memWdata_q;

`ifdef K_FRAME_WRITER_ROW_DONE_EN
   logic rowDone_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rowDone_q <= 1'b0;
      end else begin
         rowDone_q <= xfer && lastCol;
      end
   end

   assign row_done = rowDone_q;
`else
   assign row_done = 1'b0;
`endif

endmodule
